// File: rtl/block_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : block_matmul_sequencer
// Description : Tiles two MAT_DIM x MAT_DIM matrices held in synchronous-read
//               memories into TILE x TILE blocks, feeds block pairs to the
//               systolic block-multiply engine (load/start/done handshake),
//               accumulates partial block products over the inner tile index
//               and writes each finished C tile back to the C memory.
//               Loop order is ti (outer), tj, tk (inner).
// Options     : `define SA_TIMEOUT_EN adds a RUN-state watchdog that raises a
//               sticky err, pulses done and abandons the current tile when
//               sa_done does not arrive within SA_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module block_matmul_sequencer #(
  parameter int DATA_W     = 16,
  parameter int TILE       = 2,
  parameter int MAT_DIM    = 4,
  parameter int ADDR_W     = $clog2(MAT_DIM*MAT_DIM),
  parameter int SA_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          a_rd_en,
  output logic [ADDR_W-1:0]             a_rd_addr,
  input  logic [DATA_W-1:0]             a_rd_data,
  output logic                          b_rd_en,
  output logic [ADDR_W-1:0]             b_rd_addr,
  input  logic [DATA_W-1:0]             b_rd_data,
  output logic                          c_wr_en,
  output logic [ADDR_W-1:0]             c_wr_addr,
  output logic [DATA_W-1:0]             c_wr_data,
  output logic [TILE*TILE*DATA_W-1:0]   sa_block_a,
  output logic [TILE*TILE*DATA_W-1:0]   sa_block_b,
  output logic                          sa_load,
  output logic                          sa_start,
  input  logic                          sa_done,
  input  logic [TILE*TILE*DATA_W-1:0]   sa_result
);

  localparam int TT    = TILE * TILE;
  localparam int NT    = MAT_DIM / TILE;
  localparam int IDX_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int CNT_W = $clog2(TT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_ACCUM = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ti_q, tj_q, tk_q;
  logic [IDX_W-1:0]   ti_d, tj_d, tk_d;
  logic               tk_last, tj_last, ti_last;
  logic [DATA_W-1:0]  acc_q [TT];
  logic [DATA_W-1:0]  w_sum [TT];

`ifdef SA_TIMEOUT_EN
  localparam int WD_W = $clog2(SA_TIMEOUT + 1);
  logic [WD_W-1:0]    wd_q;
`endif

  // Row-major address of element e of the tile at (row_t, col_t).
  function automatic logic [ADDR_W-1:0] elem_addr(input int row_t, input int col_t, input int e);
    return ADDR_W'((row_t * TILE + e / TILE) * MAT_DIM + col_t * TILE + e % TILE);
  endfunction

  // Accumulator plus the engine result, wrapping at DATA_W bits.
  for (genvar g = 0; g < TT; g++) begin : g_sum
    assign w_sum[g] = acc_q[g] + sa_result[g*DATA_W +: DATA_W];
  end

  // Next tile indices: tk steps alone; tj steps with ti carry after a write.
  always_comb begin
    tk_last = (tk_q == IDX_LAST);
    tj_last = (tj_q == IDX_LAST);
    ti_last = (ti_q == IDX_LAST);
    tk_d    = tk_q + IDX_W'(1);
    tj_d    = tj_last ? '0 : tj_q + IDX_W'(1);
    ti_d    = tj_last ? ti_q + IDX_W'(1) : ti_q;
  end

  // Sequencer FSM; every output is registered and set up one cycle ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ti_q       <= '0;
      tj_q       <= '0;
      tk_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      a_rd_en    <= 1'b0;
      a_rd_addr  <= '0;
      b_rd_en    <= 1'b0;
      b_rd_addr  <= '0;
      c_wr_en    <= 1'b0;
      c_wr_addr  <= '0;
      c_wr_data  <= '0;
      sa_block_a <= '0;
      sa_block_b <= '0;
      sa_load    <= 1'b0;
      sa_start   <= 1'b0;
      for (int e = 0; e < TT; e++) acc_q[e] <= '0;
`ifdef SA_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            for (int e = 0; e < TT; e++) acc_q[e] <= '0;
            ti_q      <= '0;
            tj_q      <= '0;
            tk_q      <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            a_rd_en   <= 1'b1;
            a_rd_addr <= elem_addr(0, 0, 0);
            b_rd_en   <= 1'b1;
            b_rd_addr <= elem_addr(0, 0, 0);
            state_q   <= S_FETCH;
          end
        end

        S_FETCH: begin
          // Data requested in cycle e arrives in cycle e+1.
          for (int e = 0; e < TT; e++) begin
            if (int'(cnt_q) == e + 1) begin
              sa_block_a[e*DATA_W +: DATA_W] <= a_rd_data;
              sa_block_b[e*DATA_W +: DATA_W] <= b_rd_data;
            end
          end
          if (int'(cnt_q) == TT) begin
            cnt_q   <= '0;
            sa_load <= 1'b1;
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (int'(cnt_q) == TT - 1) begin
              a_rd_en <= 1'b0;
              b_rd_en <= 1'b0;
            end else begin
              a_rd_addr <= elem_addr(int'(ti_q), int'(tk_q), int'(cnt_q) + 1);
              b_rd_addr <= elem_addr(int'(tk_q), int'(tj_q), int'(cnt_q) + 1);
            end
          end
        end

        S_LOAD: begin
          sa_load  <= 1'b0;
          sa_start <= 1'b1;
`ifdef SA_TIMEOUT_EN
          wd_q     <= '0;
`endif
          state_q  <= S_RUN;
        end

        S_RUN: begin
          if (sa_done) begin
            sa_start <= 1'b0;
            state_q  <= S_ACCUM;
          end
`ifdef SA_TIMEOUT_EN
          else if (wd_q == WD_W'(SA_TIMEOUT - 1)) begin
            // Engine hung: abandon this tile without writing it.
            err      <= 1'b1;
            sa_start <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end

        S_ACCUM: begin
          for (int e = 0; e < TT; e++) acc_q[e] <= w_sum[e];
          cnt_q <= '0;
          if (tk_last) begin
            // First write goes out straight from the fresh sum.
            c_wr_en   <= 1'b1;
            c_wr_addr <= elem_addr(int'(ti_q), int'(tj_q), 0);
            c_wr_data <= w_sum[0];
            state_q   <= S_WRITE;
          end else begin
            tk_q      <= tk_d;
            a_rd_en   <= 1'b1;
            a_rd_addr <= elem_addr(int'(ti_q), int'(tk_d), 0);
            b_rd_en   <= 1'b1;
            b_rd_addr <= elem_addr(int'(tk_d), int'(tj_q), 0);
            state_q   <= S_FETCH;
          end
        end

        S_WRITE: begin
          if (int'(cnt_q) == TT - 1) begin
            c_wr_en <= 1'b0;
            cnt_q   <= '0;
            for (int e = 0; e < TT; e++) acc_q[e] <= '0;
            tk_q    <= '0;
            tj_q    <= tj_d;
            ti_q    <= ti_d;
            if (tj_last && ti_last) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= S_DONE;
            end else begin
              a_rd_en   <= 1'b1;
              a_rd_addr <= elem_addr(int'(ti_d), 0, 0);
              b_rd_en   <= 1'b1;
              b_rd_addr <= elem_addr(0, int'(tj_d), 0);
              state_q   <= S_FETCH;
            end
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            c_wr_addr <= elem_addr(int'(ti_q), int'(tj_q), int'(cnt_q) + 1);
            for (int e = 1; e < TT; e++) begin
              if (int'(cnt_q) + 1 == e) c_wr_data <= acc_q[e];
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/block_matmul_sequencer.md
Name: block_matmul_sequencer

Overview:
Initiator for the systolic block-multiply engine. It tiles two square matrices held in external synchronous-read memories into TILE x TILE blocks and feeds block pairs to the engine through its load/start/done handshake. It accumulates the partial block products over the inner tile index and writes each finished result tile to the C memory. It sits between the matrix buffers and the systolic array, and is the only driver of the array's load and start inputs.

Parameters:
DATA_W, 16, element width; all arithmetic wraps modulo 2^DATA_W
TILE, 2, block edge; equals array rows and columns
MAT_DIM, 4, matrix edge; must be a multiple of TILE
ADDR_W, $clog2(MAT_DIM*MAT_DIM), memory address width
SA_TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  reset
go  in  1  start a full C = A x B
busy  out  1  high from accepted go until done
done  out  1  one-cycle pulse when the last C write completes
err  out  1  sticky watchdog error; tied 0 without the macro
a_rd_en  out  1  A memory read enable
a_rd_addr  out  ADDR_W  A memory read address, row-major
a_rd_data  in  DATA_W  A read data, valid 1 cycle after a_rd_en
b_rd_en  out  1  B memory read enable
b_rd_addr  out  ADDR_W  B memory read address, row-major
b_rd_data  in  DATA_W  B read data, 1-cycle latency
c_wr_en  out  1  C memory write strobe
c_wr_addr  out  ADDR_W  C memory write address, row-major
c_wr_data  out  DATA_W  C memory write data
sa_block_a  out  TILE*TILE*DATA_W  A block, element e at bits [e*DATA_W +: DATA_W], row-major
sa_block_b  out  TILE*TILE*DATA_W  B block, same packing
sa_load  out  1  one-cycle load pulse to the array
sa_start  out  1  held high while the array computes
sa_done  in  1  array done level
sa_result  in  TILE*TILE*DATA_W  array result block, same packing

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, all outputs, block registers, accumulators and tile indices go to 0, and the FSM goes to IDLE. Reset in any state aborts the operation; no further memory writes are issued.
- Loop order: ti (row tile) outer, then tj, then tk inner. Each index runs 0..MAT_DIM/TILE-1.
- Element (r,c) of the A block uses address (ti*TILE+r)*MAT_DIM + tk*TILE + c.
- Element (r,c) of the B block uses address (tk*TILE+r)*MAT_DIM + tj*TILE + c.
- Element (r,c) of the C tile is written to address (ti*TILE+r)*MAT_DIM + tj*TILE + c.
- IDLE: go=1 clears the accumulator, zeroes the indices, sets busy and moves to FETCH. go is ignored in every other state.
- FETCH: lasts TILE*TILE+1 cycles.
  - In cycle e (0..T²-1), rd_en=1 on both memories with the addresses for element e.
  - Data returned in cycle e+1 is captured into block element e.
  - Then go to LOAD.
- LOAD: sa_load=1 for exactly one cycle; sa_block_a/b are stable. Then go to RUN.
- RUN: sa_start=1. When sa_done is sampled 1, go to ACCUM; sa_start is 0 from that cycle onward.
- ACCUM: one cycle. acc[e] += sa_result[e] for every e, wrapping.
  - If tk is the last index, go to WRITE.
  - Otherwise increment tk and go to FETCH.
- WRITE: T² cycles; c_wr_en=1 with elements 0..T²-1 in order. Then:
  - clear the accumulator and tk;
  - advance tj, or wrap tj to 0 and advance ti;
  - if the last tile is done, go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, busy falls in the same cycle, then go to IDLE.
- sa_block_a/b hold their values outside FETCH.
- Exactly one rd_en cycle per element per fetch; no reads are issued outside FETCH.

Optional Feature:
SA_TIMEOUT_EN.
- With the macro: a counter runs in RUN. If sa_done has not been seen after SA_TIMEOUT cycles, the block:
  - sets err to 1;
  - drops sa_start;
  - pulses done;
  - returns to IDLE without writing the current tile.
  err stays 1 until reset or the next accepted go.
- Without the macro: there is no counter, err is constant 0, and RUN waits indefinitely.

Test Plan:
1. Single tile. MAT_DIM=2, A=[1,2,3,4], B=[5,6,7,8], go -> C writes addr0..3 = 19,22,43,50; one sa_load; done once; busy low after.
2. Multiple tiles. MAT_DIM=4, B=identity, A=0..15, go -> C equals A at all 16 addresses; 8 sa_load pulses; 4 write bursts in ti,tj order.
3. Wrap-around. DATA_W=8, MAT_DIM=4, A all 200, B all 2 -> every C element = 64 (1600 mod 256).
4. go ignored while busy. go pulsed again while in RUN -> no restart; a single done pulse; write count 16.
5. Reset mid-operation. rst asserted during RUN of tile (0,1) -> next cycle all outputs 0 and no further c_wr_en; a fresh go then produces correct results.
6. Watchdog (SA_TIMEOUT_EN, SA_TIMEOUT=64). sa_done held 0 -> err=1 and done pulses 64 cycles after RUN entry; zero C writes.
